// File: rtl/seq_alu_display.sv
// seq_alu_display
// Sequential 4-function ALU (add, sub, shift-add multiply, restoring divide).
// Each result is converted to BCD with a double-dabble pass and shown on a
// multiplexed active-low 7-segment display.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   go            start request, only looked at while idle
//   a, b          W-bit unsigned operands
//   opcode        00 add, 01 sub, 10 mul, 11 div
//   result        2W-bit result (sub: magnitude, div: quotient)
//   remainder     divide remainder, 0 for other operations
//   neg, err      sub result negative / divide by zero
//   busy, done    operation in progress / one-cycle completion pulse
//   seg, an       active-low segments {g,f,e,d,c,b,a} and digit enables
module seq_alu_display #(
  parameter int W        = 4,
  parameter int ND       = 4,
  parameter int REF_BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [1:0]      opcode,
  output logic [2*W-1:0]  result,
  output logic [W-1:0]    remainder,
  output logic            neg,
  output logic            err,
  output logic            busy,
  output logic            done,
  output logic [6:0]      seg,
  output logic [ND-1:0]   an
);

  localparam int CW = $clog2(2 * W) + 1;
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;
  localparam int BW = 4 * ND;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned MAX_OP = (64'd1 << W) - 64'd1;
  localparam longint unsigned MAX_SQ = MAX_OP * MAX_OP;

  generate
    if (W < 2 || W > 8) begin : g_bad_width
      $error("seq_alu_display: W must be in 2..8");
    end
    if (!(pow10(ND) > MAX_SQ)) begin : g_bad_digits
      $error("seq_alu_display: ND too small to show the largest product");
    end
  endgenerate

  // 7-segment code for one BCD digit; non-decimal codes show blank
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

  state_t          state_r, state_nxt_s;
  logic [W-1:0]    a_r, b_r;
  logic [1:0]      op_r;
  logic [CW-1:0]   cnt_r;
  logic [2*W-1:0]  acc_r, acc_nxt_s;
  logic [2*W-1:0]  mcand_r, mcand_nxt_s;
  // multiplier for mul, dividend/quotient for div
  logic [W-1:0]    quo_r, quo_nxt_s;
  logic [W-1:0]    rem_r, rem_nxt_s;
  logic            neg_w_r, neg_nxt_s;
  logic [W:0]      div_shift_s, div_trial_s;
  logic            last_step_s, conv_last_s;

  logic [BW-1:0]   dd_bcd_r, dd_adj_s, dd_bcd_nxt_s;
  logic [2*W-1:0]  dd_bin_r, dd_bin_nxt_s;

  logic [2*W-1:0]  result_r;
  logic [W-1:0]    remainder_r;
  logic            neg_r, err_r, busy_r, done_r;
  logic [BW-1:0]   bcd_r;

  logic [REF_BITS-1:0] ps_r;
  logic [DW-1:0]   dig_r, msd_s;
  logic [DW:0]     dash_pos_s;
  logic [3:0]      sel_s;
  logic [6:0]      seg_r, seg_nxt_s;
  logic [ND-1:0]   an_r, an_nxt_s;

  assign last_step_s = (cnt_r == CW'(W - 1));
  assign conv_last_s = (cnt_r == CW'(2 * W - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (go) state_nxt_s = S_CALC;
        else    state_nxt_s = S_IDLE;
      end
      S_CALC: begin
        case (op_r)
          OP_MUL: begin
            if (last_step_s) state_nxt_s = S_CONV;
            else             state_nxt_s = S_CALC;
          end
          OP_DIV: begin
            // divide by zero finishes at once and skips conversion
            if (b_r == {W{1'b0}}) state_nxt_s = S_DONE;
            else if (last_step_s) state_nxt_s = S_CONV;
            else                  state_nxt_s = S_CALC;
          end
          default: state_nxt_s = S_CONV;
        endcase
      end
      S_CONV: begin
        if (conv_last_s) state_nxt_s = S_DONE;
        else             state_nxt_s = S_CONV;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // One CALC step of the selected operation
  always_comb begin
    acc_nxt_s   = acc_r;
    mcand_nxt_s = mcand_r;
    quo_nxt_s   = quo_r;
    rem_nxt_s   = rem_r;
    neg_nxt_s   = neg_w_r;
    div_shift_s = {rem_r, quo_r[W-1]};
    div_trial_s = div_shift_s - {1'b0, b_r};
    case (op_r)
      OP_ADD: begin
        acc_nxt_s = {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
      end
      OP_SUB: begin
        if (a_r < b_r) begin
          acc_nxt_s = {{W{1'b0}}, b_r - a_r};
          neg_nxt_s = 1'b1;
        end else begin
          acc_nxt_s = {{W{1'b0}}, a_r - b_r};
          neg_nxt_s = 1'b0;
        end
      end
      OP_MUL: begin
        if (quo_r[0]) acc_nxt_s = acc_r + mcand_r;
        else          acc_nxt_s = acc_r;
        mcand_nxt_s = mcand_r << 1;
        quo_nxt_s   = quo_r >> 1;
      end
      OP_DIV: begin
        // restoring step: a borrow (trial MSB set) means keep the shifted value
        if (div_trial_s[W]) begin
          rem_nxt_s = div_shift_s[W-1:0];
          quo_nxt_s = {quo_r[W-2:0], 1'b0};
        end else begin
          rem_nxt_s = div_trial_s[W-1:0];
          quo_nxt_s = {quo_r[W-2:0], 1'b1};
        end
        acc_nxt_s = {{W{1'b0}}, quo_nxt_s};
      end
      default: acc_nxt_s = acc_r;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift left by one
  always_comb begin
    dd_adj_s = dd_bcd_r;
    for (int i = 0; i < ND; i++) begin
      if (dd_bcd_r[4*i +: 4] >= 4'd5) dd_adj_s[4*i +: 4] = dd_bcd_r[4*i +: 4] + 4'd3;
      else                            dd_adj_s[4*i +: 4] = dd_bcd_r[4*i +: 4];
    end
    // rotate: the top BCD bit (always 0 for legal sizes) wraps into the spent binary field
    {dd_bcd_nxt_s, dd_bin_nxt_s} = {dd_adj_s[BW-2:0], dd_bin_r, dd_adj_s[BW-1]};
  end

  // Operand capture, arithmetic working registers and BCD conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      op_r     <= 2'b00;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {2*W{1'b0}};
      mcand_r  <= {2*W{1'b0}};
      quo_r    <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      neg_w_r  <= 1'b0;
      dd_bcd_r <= {BW{1'b0}};
      dd_bin_r <= {2*W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= opcode;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {2*W{1'b0}};
            mcand_r <= {{W{1'b0}}, a};
            quo_r   <= (opcode == OP_MUL) ? b : a;
            rem_r   <= {W{1'b0}};
            neg_w_r <= 1'b0;
          end
        end
        S_CALC: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= mcand_nxt_s;
          quo_r    <= quo_nxt_s;
          rem_r    <= rem_nxt_s;
          neg_w_r  <= neg_nxt_s;
          dd_bin_r <= acc_nxt_s;
          dd_bcd_r <= {BW{1'b0}};
          if (state_nxt_s == S_CALC) cnt_r <= cnt_r + CW'(1);
          else                       cnt_r <= {CW{1'b0}};
        end
        S_CONV: begin
          dd_bcd_r <= dd_bcd_nxt_s;
          dd_bin_r <= dd_bin_nxt_s;
          cnt_r    <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Visible results and status, updated only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r    <= {2*W{1'b0}};
      remainder_r <= {W{1'b0}};
      neg_r       <= 1'b0;
      err_r       <= 1'b0;
      bcd_r       <= {BW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_nxt_s == S_DONE);
      if (state_nxt_s == S_DONE) begin
        if (state_r == S_CONV) begin
          result_r    <= acc_r;
          remainder_r <= (op_r == OP_DIV) ? rem_r : {W{1'b0}};
          neg_r       <= neg_w_r;
          err_r       <= 1'b0;
          bcd_r       <= dd_bcd_nxt_s;
        end else begin
          // only divide by zero reaches DONE straight from CALC
          result_r    <= {2*W{1'b0}};
          remainder_r <= {W{1'b0}};
          neg_r       <= 1'b0;
          err_r       <= 1'b1;
          bcd_r       <= {BW{1'b0}};
        end
      end
    end
  end

  // Segment pattern for the currently selected digit
  always_comb begin
    msd_s = {DW{1'b0}};
    sel_s = 4'd0;
    for (int i = 0; i < ND; i++) begin
      if (bcd_r[4*i +: 4] != 4'd0) msd_s = DW'(i);
      else                         msd_s = msd_s;
      if (dig_r == DW'(i)) sel_s = bcd_r[4*i +: 4];
      else                 sel_s = sel_s;
    end
    dash_pos_s = {1'b0, msd_s} + (DW+1)'(1);
    if (err_r)                                      seg_nxt_s = SEG_DASH;
    else if (dig_r <= msd_s)                        seg_nxt_s = seg_code(sel_s);
    else if (neg_r && ({1'b0, dig_r} == dash_pos_s)) seg_nxt_s = SEG_DASH;
    else                                            seg_nxt_s = SEG_BLANK;
    an_nxt_s = ~(ND'(1) << dig_r);
  end

  // Free-running refresh prescaler, digit scan and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_r  <= {REF_BITS{1'b0}};
      dig_r <= {DW{1'b0}};
      seg_r <= 7'b1000000;
      an_r  <= ~ND'(1);
    end else begin
      ps_r  <= ps_r + REF_BITS'(1);
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
      if (ps_r == {REF_BITS{1'b1}}) begin
        if (dig_r == DW'(ND - 1)) dig_r <= {DW{1'b0}};
        else                      dig_r <= dig_r + DW'(1);
      end
    end
  end

  assign result    = result_r;
  assign remainder = remainder_r;
  assign neg       = neg_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign seg       = seg_r;
  assign an        = an_r;

endmodule
